ega_init_seq: RTL and testbench
===============================

# ega_init_seq

Bus-initiator sequencer that brings the EGA video block out of power-on state without BIOS help. On a start pulse it requests the CPU-side bus, resets the attribute flip-flop, and programs the palette, sequencer and graphics-controller registers from a constant table. It then writes the mode-enable hack port and, optionally, clears the displayed VRAM. It sits between the system bus arbiter and `video_ega`, driving the same address, data and strobe signals the CPU normally drives.

## Interface
Parameters:
- `WR_GAP`, 1: idle cycles inserted after every strobe, with range 1..7. A value of at least 1 is mandatory because the EGA pipelines memory writes.
- `RD_TIMEOUT`, 16: cycles to wait for `iSel` after the `0x3DA` read, with range 2..255.

Ports:
- `iClk` in 1: single clock; every register is clocked on its rising edge.
- `iRst` in 1: reset, synchronous and active-high.
- `iStart` in 1: one-cycle start pulse; ignored while `oBusy`.
- `oReq` out 1: bus request; high from accepted start until DONE.
- `iGnt` in 1: bus grant from the arbiter.
- `oAddr` out 20: bus address; I/O cycles use bits [11:0] with the upper bits zero.
- `oWrData` out 8: write data.
- `oWrMem`, `oRdMem`, `oWrIo`, `oRdIo` out 1 each: one-cycle strobes, at most one high per cycle.
- `iRdData` in 8: read data (unused apart from capture).
- `iSel` in 1: read-data-valid.
- `oBusy` out 1: sequence in progress.
- `oDone` out 1: one-cycle pulse on completion.
- `oErr` out 1: sticky flag for a timeout on the flip-flop read; cleared by the next accepted start.

## Operation
- All outputs are registered. Reset values are 0 for every output, including `oAddr` and `oWrData`.
- States: IDLE, FF_RD, FF_WAIT, TABLE, MODE, CLEAR, DONE.
  - IDLE: when `iStart` is seen, set `oBusy` and `oReq`, clear `oErr`, then go to FF_RD.
  - FF_RD: in the first cycle with `iGnt`, pulse `oRdIo` with address `0x3DA`, then go to FF_WAIT.
  - FF_WAIT: wait for `iSel`. If it arrives, go to TABLE. If `RD_TIMEOUT` cycles pass first, set `oErr` and go to TABLE anyway.
  - TABLE: walk 51 entries, each a {port[11:0], data[7:0]} pair, and issue one `oWrIo` per entry:
    - entries 0..31: `0x3C0` index then data for palette indices 0..15. Values are 00,01,02,03,04,05,14,07,38,39,3A,3B,3C,3D,3E,3F.
    - entry 32: `0x3C0` ← `0x20`.
    - entries 33–34: `0x3C4` ← 2, `0x3C5` ← `0x0F`.
    - entries 35..50: `0x3CE`/`0x3CF` pairs for graphics indices 0,1,2,3,4,5,7,8 with data 00,00,00,00,00,00,0F,FF.
  - MODE: one `oWrIo` writing `0x0D` to port `0x0FE`.
  - CLEAR: described under Configuration.
  - DONE: pulse `oDone` for one cycle, drop `oBusy` and `oReq`, return to IDLE.
- Strobe spacing: a strobe fires only in a cycle with `iGnt` high and the gap counter at zero. After a strobe, the next `WR_GAP` cycles are idle.
- If `iGnt` drops, the sequencer holds its position with no strobe. `oAddr` and `oWrData` stay stable from one cycle before a strobe until `WR_GAP` cycles after it.
- The table index is 6 bits. The clear counter is 13 bits and counts 0..7999 exactly, with no wrap.
- Reset mid-sequence: the next edge returns to IDLE with every output 0, and no partial strobe is held.
- `iStart` coincident with `iRst`: ignored.

## Timing
- Start to first `oRdIo`: 2 cycles with `iGnt` held high.
- `video_ega` returns `iSel` 1 cycle after the strobe. Leaving FF_WAIT takes 1 cycle.
- With `iGnt` held high:
  - TABLE plus MODE take 52 × (1 + `WR_GAP`) cycles.
  - CLEAR takes 8000 × (1 + `WR_GAP`) cycles.
  - `oDone` follows the last strobe after `WR_GAP` + 1 cycles.

## Configuration
- `EGA_INIT_CLEAR_EN` defined: after MODE, CLEAR issues 8000 `oWrMem` strobes with data `0x00` to `0xA0000`..`0xA1F3F`, incrementing by 1. The earlier register settings (plane mask `0x0F`, bit mask `0xFF`, write mode 0) ensure all four planes are zeroed.
- `EGA_INIT_CLEAR_EN` undefined: the CLEAR state and the 13-bit counter are not compiled, and MODE goes directly to DONE.

## Structure
- Package `ega_init_pkg` holds:
  - the state enum;
  - the table-entry struct;
  - port constants for 3C0, 3C4, 3C5, 3CE, 3CF, 3DA and 0FE;
  - `TABLE_LEN = 51`;
  - `CLEAR_BASE = 0xA0000`;
  - `CLEAR_LEN = 8000`.
- Sub-module `ega_init_rom`: combinational table lookup from the 6-bit index to {port, data}.

## Test plan
- Reset, then `iStart`, `iGnt` = 1, `WR_GAP` = 1, and a responder returning `iSel` after 1 cycle. Expected:
  - `oRdIo` at `0x3DA`, then 51 `oWrIo` cycles in table order, starting with (`0x3C0`, `0x00`) and (`0x3C0`, `0x00`) and ending with (`0x3CF`, `0xFF`);
  - then (`0x0FE`, `0x0D`);
  - then `oDone`, with `oErr` = 0.
- `iSel` never asserted. Expected: `oErr` rises exactly `RD_TIMEOUT` cycles after `oRdIo`, the table still runs, `oErr` stays 1 after `oDone`, and a new `iStart` clears it.
- `iGnt` low for 5 cycles in the middle of the table. Expected: no strobes during the gap, no skipped or duplicated entries, and `oAddr`/`oWrData` stable across the stall.
- `iRst` asserted during entry 20. Expected: all outputs 0 on the next edge, and a restart replays from the `0x3DA` read.
- With `EGA_INIT_CLEAR_EN` defined:
  - expect exactly 8000 `oWrMem` strobes, first `0xA0000`, last `0xA1F3F`, data 0;
  - connected to `video_ega`, all planes read 0 at offsets 0..7999 afterwards.
- `iStart` pulsed while busy. Expected: ignored, with no restart and total cycle count unchanged.

Source files
------------

// File: rtl/ega_init_pkg.sv
// Shared types and constants for the EGA power-on init sequencer.
// The optional VRAM clear is enabled with EGA_INIT_CLEAR_EN.
package ega_init_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FF_RD,
      ST_FF_WAIT,
      ST_TABLE,
      ST_MODE,
      ST_CLEAR,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [11:0] port;
      logic [7:0]  data;
   } tbl_entry_t;

   localparam logic [11:0] IO_3C0 = 12'h3C0;
   localparam logic [11:0] IO_3C4 = 12'h3C4;
   localparam logic [11:0] IO_3C5 = 12'h3C5;
   localparam logic [11:0] IO_3CE = 12'h3CE;
   localparam logic [11:0] IO_3CF = 12'h3CF;
   localparam logic [11:0] IO_3DA = 12'h3DA;
   localparam logic [11:0] IO_0FE = 12'h0FE;

   localparam logic [7:0]  MODE_VAL   = 8'h0D;
   localparam int          TABLE_LEN  = 51;
   localparam logic [19:0] CLEAR_BASE = 20'hA0000;
   localparam int          CLEAR_LEN  = 8000;

   // Default CGA-like palette: brown at index 6, bright colours at 8..15.
   function automatic logic [7:0] pal_val(input logic [3:0] i);
      if (i == 4'd6)
         return 8'h14;
      else if (i[3])
         return {4'h3, i};
      else
         return {4'h0, i};
   endfunction

endpackage

// File: rtl/ega_init_rom.sv
// Constant register-programming table: 6-bit index to {port, data}.
module ega_init_rom
   import ega_init_pkg::*;
(
   input  logic [5:0]  idx,
   output tbl_entry_t  entry
);

   always_comb begin
      entry = {12'h000, 8'h00};
      if (!idx[5]) begin
         // Attribute controller: index write then data write per palette slot.
         if (idx[0])
            entry = {IO_3C0, pal_val(idx[4:1])};
         else
            entry = {IO_3C0, 4'h0, idx[4:1]};
      end else begin
         case (idx)
            6'd32: entry = {IO_3C0, 8'h20};
            6'd33: entry = {IO_3C4, 8'h02};
            6'd34: entry = {IO_3C5, 8'h0F};
            6'd35: entry = {IO_3CE, 8'h00};
            6'd36: entry = {IO_3CF, 8'h00};
            6'd37: entry = {IO_3CE, 8'h01};
            6'd38: entry = {IO_3CF, 8'h00};
            6'd39: entry = {IO_3CE, 8'h02};
            6'd40: entry = {IO_3CF, 8'h00};
            6'd41: entry = {IO_3CE, 8'h03};
            6'd42: entry = {IO_3CF, 8'h00};
            6'd43: entry = {IO_3CE, 8'h04};
            6'd44: entry = {IO_3CF, 8'h00};
            6'd45: entry = {IO_3CE, 8'h05};
            6'd46: entry = {IO_3CF, 8'h00};
            6'd47: entry = {IO_3CE, 8'h07};
            6'd48: entry = {IO_3CF, 8'h0F};
            6'd49: entry = {IO_3CE, 8'h08};
            6'd50: entry = {IO_3CF, 8'hFF};
            default: entry = {12'h000, 8'h00};
         endcase
      end
   end

endmodule

// File: rtl/ega_init_seq.sv
// Bus-initiator that programs the EGA block from a constant table after power-on.
// Define EGA_INIT_CLEAR_EN to also zero the displayed VRAM after the mode write.
module ega_init_seq
   import ega_init_pkg::*;
#(
   parameter int unsigned WR_GAP     = 1,
   parameter int unsigned RD_TIMEOUT = 16
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iStart,
   output logic        oReq,
   input  logic        iGnt,
   output logic [19:0] oAddr,
   output logic [7:0]  oWrData,
   output logic        oWrMem,
   output logic        oRdMem,
   output logic        oWrIo,
   output logic        oRdIo,
   input  logic [7:0]  iRdData,
   input  logic        iSel,
   output logic        oBusy,
   output logic        oDone,
   output logic        oErr
);

   localparam logic [2:0] GAP_LOAD = 3'(WR_GAP);
   localparam logic [7:0] TO_LAST  = 8'(RD_TIMEOUT - 1);

   state_e      state;
   logic [5:0]  idx;
   logic [2:0]  gap;
   logic [7:0]  to_cnt;
   logic [7:0]  unused_rd_cap;
   tbl_entry_t  entry;
   logic        fire;
`ifdef EGA_INIT_CLEAR_EN
   logic [12:0] clr_cnt;
`endif

   ega_init_rom u_rom (
      .idx   (idx),
      .entry (entry)
   );

   always_comb begin
      fire = 1'b0;
      if (iGnt && gap == 3'd0) begin
         case (state)
            ST_FF_RD, ST_TABLE, ST_MODE, ST_CLEAR: fire = 1'b1;
            default:                               fire = 1'b0;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state         <= ST_IDLE;
         idx           <= 6'd0;
         gap           <= 3'd0;
         to_cnt        <= 8'd0;
         unused_rd_cap <= 8'h00;
         oReq          <= 1'b0;
         oBusy         <= 1'b0;
         oDone         <= 1'b0;
         oErr          <= 1'b0;
         oAddr         <= 20'h00000;
         oWrData       <= 8'h00;
         oWrMem        <= 1'b0;
         oRdMem        <= 1'b0;
         oWrIo         <= 1'b0;
         oRdIo         <= 1'b0;
`ifdef EGA_INIT_CLEAR_EN
         clr_cnt       <= 13'd0;
`endif
      end else begin
         oWrMem <= 1'b0;
         oRdMem <= 1'b0;
         oWrIo  <= 1'b0;
         oRdIo  <= 1'b0;
         oDone  <= 1'b0;

         if (fire)
            gap <= GAP_LOAD;
         else if (gap != 3'd0)
            gap <= gap - 3'd1;

         // The previous strobe's address is held through most of its gap; the
         // next target is presented in the last gap cycle, ahead of its strobe.
         if (gap == 3'd1) begin
            case (state)
               ST_TABLE: begin
                  oAddr   <= {8'h00, entry.port};
                  oWrData <= entry.data;
               end
               ST_MODE: begin
                  oAddr   <= {8'h00, IO_0FE};
                  oWrData <= MODE_VAL;
               end
`ifdef EGA_INIT_CLEAR_EN
               ST_CLEAR: begin
                  oAddr   <= CLEAR_BASE + {7'd0, clr_cnt};
                  oWrData <= 8'h00;
               end
`endif
               default: ;
            endcase
         end

         case (state)
            ST_IDLE: begin
               if (iStart) begin
                  oBusy   <= 1'b1;
                  oReq    <= 1'b1;
                  oErr    <= 1'b0;
                  oAddr   <= {8'h00, IO_3DA};
                  oWrData <= 8'h00;
                  idx     <= 6'd0;
                  to_cnt  <= 8'd0;
`ifdef EGA_INIT_CLEAR_EN
                  clr_cnt <= 13'd0;
`endif
                  state   <= ST_FF_RD;
               end
            end
            ST_FF_RD: begin
               if (fire) begin
                  oRdIo  <= 1'b1;
                  to_cnt <= 8'd0;
                  state  <= ST_FF_WAIT;
               end
            end
            ST_FF_WAIT: begin
               // Reading 0x3DA resets the attribute flip-flop; the data is irrelevant.
               if (iSel || to_cnt == TO_LAST) begin
                  if (iSel)
                     unused_rd_cap <= iRdData;
                  else
                     oErr <= 1'b1;
                  oAddr   <= {8'h00, entry.port};
                  oWrData <= entry.data;
                  state   <= ST_TABLE;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            ST_TABLE: begin
               if (fire) begin
                  oWrIo <= 1'b1;
                  idx   <= idx + 6'd1;
                  if (idx == 6'(TABLE_LEN - 1))
                     state <= ST_MODE;
               end
            end
            ST_MODE: begin
               if (fire) begin
                  oWrIo <= 1'b1;
`ifdef EGA_INIT_CLEAR_EN
                  state <= ST_CLEAR;
`else
                  state <= ST_DONE;
`endif
               end
            end
`ifdef EGA_INIT_CLEAR_EN
            ST_CLEAR: begin
               if (fire) begin
                  oWrMem <= 1'b1;
                  if (clr_cnt == 13'(CLEAR_LEN - 1))
                     state <= ST_DONE;
                  else
                     clr_cnt <= clr_cnt + 13'd1;
               end
            end
`endif
            ST_DONE: begin
               if (gap == 3'd0) begin
                  oDone <= 1'b1;
                  oBusy <= 1'b0;
                  oReq  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ega_init_seq.sv
// Directed bench for ega_init_seq (WR_GAP=1, RD_TIMEOUT=16); honours EGA_INIT_CLEAR_EN.
module tb_ega_init_seq;

`ifdef EGA_INIT_CLEAR_EN
   localparam int CLR_CYC    = 16000;
   localparam int DONE_LIMIT = 17000;
`else
   localparam int CLR_CYC    = 0;
   localparam int DONE_LIMIT = 400;
`endif

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic        iStart = 1'b0;
   logic        iGnt = 1'b1;
   logic        iSel = 1'b0;
   logic [7:0]  iRdData = 8'h00;
   logic        oReq, oWrMem, oRdMem, oWrIo, oRdIo, oBusy, oDone, oErr;
   logic [19:0] oAddr;
   logic [7:0]  oWrData;

   ega_init_seq #(.WR_GAP(1), .RD_TIMEOUT(16)) dut (
      .iClk    (iClk),
      .iRst    (iRst),
      .iStart  (iStart),
      .oReq    (oReq),
      .iGnt    (iGnt),
      .oAddr   (oAddr),
      .oWrData (oWrData),
      .oWrMem  (oWrMem),
      .oRdMem  (oRdMem),
      .oWrIo   (oWrIo),
      .oRdIo   (oRdIo),
      .iRdData (iRdData),
      .iSel    (iSel),
      .oBusy   (oBusy),
      .oDone   (oDone),
      .oErr    (oErr)
   );

   always #5 iClk = ~iClk;

   // {port, data} in table order, written out by hand
   logic [19:0] exp_tab [0:50] = '{
      20'h3C000, 20'h3C000, 20'h3C001, 20'h3C001, 20'h3C002, 20'h3C002, 20'h3C003, 20'h3C003,
      20'h3C004, 20'h3C004, 20'h3C005, 20'h3C005, 20'h3C006, 20'h3C014, 20'h3C007, 20'h3C007,
      20'h3C008, 20'h3C038, 20'h3C009, 20'h3C039, 20'h3C00A, 20'h3C03A, 20'h3C00B, 20'h3C03B,
      20'h3C00C, 20'h3C03C, 20'h3C00D, 20'h3C03D, 20'h3C00E, 20'h3C03E, 20'h3C00F, 20'h3C03F,
      20'h3C020, 20'h3C402, 20'h3C50F,
      20'h3CE00, 20'h3CF00, 20'h3CE01, 20'h3CF00, 20'h3CE02, 20'h3CF00, 20'h3CE03, 20'h3CF00,
      20'h3CE04, 20'h3CF00, 20'h3CE05, 20'h3CF00, 20'h3CE07, 20'h3CF0F, 20'h3CE08, 20'h3CFFF
   };

   typedef struct {
      int          cyc;
      logic [3:0]  kind;
      logic [19:0] addr;
      logic [7:0]  data;
   } ev_t;

   ev_t         evq[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          last_strobe_cyc = 0;
   int          err_rise_cyc = 0;
   logic        err_q = 1'b0;
   logic        sel_en = 1'b1;
   int          mem_cnt = 0;
   int          mem_bad = 0;
   logic [19:0] mem_first = 20'h0;
   logic [19:0] mem_last = 20'h0;

   // video_ega stand-in: read data valid one cycle after the read strobe
   always @(posedge iClk) begin
      iSel    <= sel_en && oRdIo;
      iRdData <= 8'h5A;
   end

   always @(posedge iClk) begin
      logic [3:0] kind;
      #1;
      cyc++;
      kind = {oWrMem, oRdMem, oWrIo, oRdIo};
      if (oErr && !err_q) err_rise_cyc = cyc;
      err_q = oErr;
      if (kind != 4'b0000) begin
         last_strobe_cyc = cyc;
         n_checks++;
         if ($countones(kind) != 1) begin
            n_fail++;
            $display("FAIL strobe_onehot: got %b required one bit set at cycle %0d", kind, cyc);
         end
         if (oWrMem) begin
            if (mem_cnt == 0) mem_first = oAddr;
            mem_last = oAddr;
            if (oWrData !== 8'h00 || oAddr !== 20'hA0000 + 20'(mem_cnt)) mem_bad++;
            mem_cnt++;
         end else begin
            evq.push_back('{cyc, kind, oAddr, oWrData});
         end
      end
   end

   task automatic pulse_start(output int c0);
      @(negedge iClk);
      iStart = 1'b1;
      c0 = cyc;
      @(negedge iClk);
      iStart = 1'b0;
   endtask

   task automatic wait_done(output bit ok, output int dcyc);
      ok = 1'b0;
      dcyc = 0;
      for (int i = 0; i < DONE_LIMIT; i++) begin
         @(negedge iClk);
         if (oDone) begin
            ok = 1'b1;
            dcyc = cyc;
            break;
         end
      end
   endtask

   task automatic wait_events(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge iClk);
         if (evq.size() == n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      iRst = 1'b1;
      iStart = 1'b1;
      repeat (3) @(negedge iClk);
      n_checks++; if (oAddr !== 20'h0)   begin n_fail++; $display("FAIL reset_addr: got %h required 0", oAddr); end
      n_checks++; if (oWrData !== 8'h0)  begin n_fail++; $display("FAIL reset_wrdata: got %h required 0", oWrData); end
      n_checks++; if ({oWrMem, oRdMem, oWrIo, oRdIo} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes: got %b required 0000", {oWrMem, oRdMem, oWrIo, oRdIo}); end
      n_checks++; if ({oReq, oBusy, oDone, oErr} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {oReq, oBusy, oDone, oErr}); end
      iRst = 1'b0;
      iStart = 1'b0;
      repeat (2) @(negedge iClk);
      n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL start_during_reset: busy got %b required 0", oBusy); end
   endtask

   task automatic test_normal;
      int c0, dcyc, sp_bad;
      bit ok;
      evq.delete();
      mem_cnt = 0; mem_bad = 0;
      pulse_start(c0);
      n_checks++; if ({oBusy, oReq} !== 2'b11) begin n_fail++; $display("FAIL normal_busy_req: got %b required 11", {oBusy, oReq}); end
      wait_done(ok, dcyc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL normal_done: oDone not seen within %0d cycles", DONE_LIMIT); end
      n_checks++; if (oErr !== 1'b0) begin n_fail++; $display("FAIL normal_err: got %b required 0", oErr); end
      n_checks++; if (dcyc - last_strobe_cyc != 2) begin n_fail++; $display("FAIL normal_done_lag: got %0d required 2", dcyc - last_strobe_cyc); end
      n_checks++; if (evq.size() != 53) begin n_fail++; $display("FAIL normal_count: got %0d required 53", evq.size()); end
      if (evq.size() == 53) begin
         n_checks++; if ({evq[0].kind, evq[0].addr} !== {4'b0001, 20'h003DA}) begin n_fail++; $display("FAIL normal_ffread: got %b %h required 0001 003DA", evq[0].kind, evq[0].addr); end
         n_checks++; if (evq[0].cyc - c0 != 2) begin n_fail++; $display("FAIL normal_start_lat: got %0d required 2", evq[0].cyc - c0); end
         for (int i = 0; i < 51; i++) begin
            n_checks++;
            if ({evq[i+1].kind, evq[i+1].addr, evq[i+1].data} !== {4'b0010, 8'h00, exp_tab[i]}) begin
               n_fail++;
               $display("FAIL normal_entry%0d: got %b %h %h required 0010 %h", i, evq[i+1].kind, evq[i+1].addr, evq[i+1].data, exp_tab[i]);
            end
         end
         n_checks++; if ({evq[52].kind, evq[52].addr, evq[52].data} !== {4'b0010, 20'h000FE, 8'h0D}) begin n_fail++; $display("FAIL normal_mode: got %b %h %h required 0010 000FE 0D", evq[52].kind, evq[52].addr, evq[52].data); end
         sp_bad = 0;
         for (int i = 1; i < 52; i++) if (evq[i+1].cyc - evq[i].cyc != 2) sp_bad++;
         n_checks++; if (sp_bad != 0) begin n_fail++; $display("FAIL normal_spacing: got %0d bad gaps required 0", sp_bad); end
         n_checks++; if (dcyc - evq[1].cyc != 104 + CLR_CYC) begin n_fail++; $display("FAIL normal_table_time: got %0d required %0d", dcyc - evq[1].cyc, 104 + CLR_CYC); end
      end
`ifdef EGA_INIT_CLEAR_EN
      n_checks++; if (mem_cnt != 8000) begin n_fail++; $display("FAIL clear_count: got %0d required 8000", mem_cnt); end
      n_checks++; if (mem_first !== 20'hA0000) begin n_fail++; $display("FAIL clear_first: got %h required A0000", mem_first); end
      n_checks++; if (mem_last !== 20'hA1F3F) begin n_fail++; $display("FAIL clear_last: got %h required A1F3F", mem_last); end
      n_checks++; if (mem_bad != 0) begin n_fail++; $display("FAIL clear_order_data: got %0d bad writes required 0", mem_bad); end
`else
      n_checks++; if (mem_cnt != 0) begin n_fail++; $display("FAIL no_clear: got %0d memory writes required 0", mem_cnt); end
`endif
      @(negedge iClk);
      n_checks++; if ({oDone, oBusy, oReq} !== 3'b000) begin n_fail++; $display("FAIL normal_after_done: got %b required 000", {oDone, oBusy, oReq}); end
   endtask

   task automatic test_timeout;
      int c0, dcyc;
      bit ok;
      sel_en = 1'b0;
      evq.delete();
      pulse_start(c0);
      wait_done(ok, dcyc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_done: oDone not seen within %0d cycles", DONE_LIMIT); end
      n_checks++; if (evq.size() != 53) begin n_fail++; $display("FAIL timeout_count: got %0d required 53", evq.size()); end
      if (evq.size() > 0) begin
         n_checks++; if (err_rise_cyc - evq[0].cyc != 16) begin n_fail++; $display("FAIL timeout_err_time: got %0d required 16", err_rise_cyc - evq[0].cyc); end
      end
      n_checks++; if (oErr !== 1'b1) begin n_fail++; $display("FAIL timeout_err_at_done: got %b required 1", oErr); end
      repeat (3) @(negedge iClk);
      n_checks++; if (oErr !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %b required 1", oErr); end
      sel_en = 1'b1;
      pulse_start(c0);
      n_checks++; if (oErr !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b required 0", oErr); end
      wait_done(ok, dcyc);
      n_checks++; if (!ok || oErr !== 1'b0) begin n_fail++; $display("FAIL timeout_rerun: done %b err %b required 1 0", ok, oErr); end
   endtask

   task automatic test_stall;
      int c0, dcyc, n_before, bad;
      bit ok;
      logic [19:0] a;
      logic [7:0]  d;
      evq.delete();
      pulse_start(c0);
      wait_events(21, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_reach: got %0d events required 21", evq.size()); end
      @(negedge iClk);
      iGnt = 1'b0;
      a = oAddr;
      d = oWrData;
      n_before = evq.size();
      bad = 0;
      repeat (5) begin
         @(negedge iClk);
         if (oAddr !== a || oWrData !== d || {oWrMem, oRdMem, oWrIo, oRdIo} != 4'b0) bad++;
      end
      iGnt = 1'b1;
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable cycles required 0", bad); end
      n_checks++; if (evq.size() != n_before) begin n_fail++; $display("FAIL stall_nostrobe: got %0d events required %0d", evq.size(), n_before); end
      wait_done(ok, dcyc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_done: oDone not seen within %0d cycles", DONE_LIMIT); end
      n_checks++; if (evq.size() != 53) begin n_fail++; $display("FAIL stall_count: got %0d required 53", evq.size()); end
      if (evq.size() == 53) begin
         for (int i = 0; i < 51; i++) begin
            n_checks++;
            if ({evq[i+1].kind, evq[i+1].addr, evq[i+1].data} !== {4'b0010, 8'h00, exp_tab[i]}) begin
               n_fail++;
               $display("FAIL stall_entry%0d: got %b %h %h required 0010 %h", i, evq[i+1].kind, evq[i+1].addr, evq[i+1].data, exp_tab[i]);
            end
         end
         n_checks++; if (evq[21].cyc - evq[20].cyc != 7) begin n_fail++; $display("FAIL stall_gap: got %0d required 7", evq[21].cyc - evq[20].cyc); end
      end
   endtask

   task automatic test_reset_mid;
      int c0, dcyc;
      bit ok;
      evq.delete();
      pulse_start(c0);
      wait_events(22, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_reach: got %0d events required 22", evq.size()); end
      iRst = 1'b1;
      @(negedge iClk);
      n_checks++; if ({oAddr, oWrData} !== 28'h0) begin n_fail++; $display("FAIL rstmid_bus: got %h %h required 0 0", oAddr, oWrData); end
      n_checks++; if ({oWrMem, oRdMem, oWrIo, oRdIo, oReq, oBusy, oDone, oErr} !== 8'h0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b required 00000000", {oWrMem, oRdMem, oWrIo, oRdIo, oReq, oBusy, oDone, oErr}); end
      iRst = 1'b0;
      @(negedge iClk);
      n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: busy got %b required 0", oBusy); end
      evq.delete();
      pulse_start(c0);
      wait_done(ok, dcyc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_done: oDone not seen within %0d cycles", DONE_LIMIT); end
      n_checks++; if (evq.size() != 53) begin n_fail++; $display("FAIL rstmid_count: got %0d required 53", evq.size()); end
      if (evq.size() == 53) begin
         n_checks++; if ({evq[0].kind, evq[0].addr} !== {4'b0001, 20'h003DA} || evq[0].cyc - c0 != 2) begin n_fail++; $display("FAIL rstmid_replay: got %b %h lat %0d required 0001 003DA lat 2", evq[0].kind, evq[0].addr, evq[0].cyc - c0); end
         n_checks++; if ({evq[1].addr[11:0], evq[1].data} !== exp_tab[0]) begin n_fail++; $display("FAIL rstmid_entry0: got %h %h required %h", evq[1].addr, evq[1].data, exp_tab[0]); end
      end
   endtask

   task automatic test_busy_start;
      int c0, dcyc, n_rd;
      bit ok;
      evq.delete();
      pulse_start(c0);
      repeat (3) @(negedge iClk);
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      wait_events(30, ok);
      iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      wait_done(ok, dcyc);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_done: oDone not seen within %0d cycles", DONE_LIMIT); end
      n_checks++; if (dcyc - c0 != 109 + CLR_CYC) begin n_fail++; $display("FAIL busy_total: got %0d cycles required %0d", dcyc - c0, 109 + CLR_CYC); end
      n_rd = 0;
      foreach (evq[i]) if (evq[i].kind == 4'b0001) n_rd++;
      n_checks++; if (n_rd != 1 || evq.size() != 53) begin n_fail++; $display("FAIL busy_norestart: got %0d reads %0d events required 1 53", n_rd, evq.size()); end
      repeat (3) @(negedge iClk);
      n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %b required 0", oBusy); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_timeout();
      test_stall();
      test_reset_mid();
      test_busy_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
